// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath with a 16-entry register file, PC, IR, MAR, MDR, Y, HI, LO, 64-bit Z and ALU.
// Latency: the bus and the ALU are combinational; every register load lands on the next rising clock edge.
// Backpressure: none; each enabled load completes on the edge where it is requested.
// Ports: clock, clear (async active-low); Mdatain/Read feed MDR; opcode/Cin steer the ALU;
//        *out enables choose the bus source, *in enables load from the bus; IncPC steps the PC;
//        BusMuxOut exposes the internal bus.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic [4:0]  opcode,
  input  logic        Cin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        IncPC,
  output logic [31:0] BusMuxOut
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [15:0] r_out_en;
  logic [15:0] r_in_en;
  logic [31:0] gpr [16];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo, z_high, z_low;
  logic [63:0] alu_res;

  assign r_out_en = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in_en  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // Bus mux: sources are applied lowest priority first so that a later
  // assignment overrides; the register loop runs R15 down to R0, leaving R0 on top.
  always_comb begin
    BusMuxOut = '0;
    if (MDRout)   BusMuxOut = mdr;
    if (PCout)    BusMuxOut = pc;
    if (Zlowout)  BusMuxOut = z_low;
    if (Zhighout) BusMuxOut = z_high;
    if (LOout)    BusMuxOut = lo;
    if (HIout)    BusMuxOut = hi;
    for (int i = 15; i >= 0; i--) begin
      if (r_out_en[i]) BusMuxOut = gpr[i];
    end
  end

  // ALU operands: A is always Y, B is whatever is on the bus.
  logic [31:0] a, b;
  logic [4:0]  sh;
  logic [63:0] rot_r, rot_l;
  logic [31:0] sra;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic signed [63:0] a_ext, b_ext, prod;

  assign a  = y;
  assign b  = BusMuxOut;
  assign sh = b[4:0];

  // Rotating a doubled word: the window that falls out is the rotated value,
  // and a zero amount naturally returns A.
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;
  assign sra   = $signed(a) >>> sh;

  // Signed divide built from magnitudes so that the overflowing 0x80000000 / -1
  // case simply wraps instead of depending on the native signed divide.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a[31] ? (~r_mag + 32'd1) : r_mag;

  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign prod  = a_ext * b_ext;

  always_comb begin
    alu_res = 64'h0;
    case (opcode)
      OP_ADD:  alu_res = {32'h0, a + b + {31'h0, Cin}};
      OP_SUB:  alu_res = {32'h0, a - b};
      OP_AND:  alu_res = {32'h0, a & b};
      OP_OR:   alu_res = {32'h0, a | b};
      OP_ROR:  alu_res = {32'h0, rot_r[31:0]};
      OP_ROL:  alu_res = {32'h0, rot_l[63:32]};
      OP_SHR:  alu_res = {32'h0, a >> sh};
      OP_SHRA: alu_res = {32'h0, sra};
      OP_SHL:  alu_res = {32'h0, a << sh};
      OP_DIV:  alu_res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quot};
      OP_MUL:  alu_res = prod;
      OP_NEG:  alu_res = {32'h0, ~b + 32'd1};
      OP_NOT:  alu_res = {32'h0, ~b};
      default: alu_res = 64'h0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in_en[i]) gpr[i] <= BusMuxOut;
      end
    end
  end

  // A bus load takes precedence over the self-increment.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)     pc <= '0;
    else if (PCin)  pc <= BusMuxOut;
    else if (IncPC) pc <= pc + 32'd1;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)     mdr <= '0;
    else if (MDRin) mdr <= Read ? Mdatain : BusMuxOut;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ir     <= '0;
      mar    <= '0;
      y      <= '0;
      hi     <= '0;
      lo     <= '0;
      z_high <= '0;
      z_low  <= '0;
    end else begin
      if (IRin)    ir     <= BusMuxOut;
      if (MARin)   mar    <= BusMuxOut;
      if (Yin)     y      <= BusMuxOut;
      if (HIin)    hi     <= BusMuxOut;
      if (LOin)    lo     <= BusMuxOut;
      if (ZHighIn) z_high <= alu_res[63:32];
      if (ZLowIn)  z_low  <= alu_res[31:0];
    end
  end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: randomized and directed stimulus for data_path, scored against a behavioural datapath model.
// Latency: bus checks are sampled mid-cycle on the falling edge of the cycle that drives them.
// Backpressure: none; stimulus and monitor are decoupled through an expected-value queue.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read;
  logic [4:0]  opcode;
  logic        Cin;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic [15:0] rout, rin;
  logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC;
  logic [31:0] BusMuxOut;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .opcode(opcode), .Cin(Cin),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .IncPC(IncPC), .BusMuxOut(BusMuxOut)
  );

  // Behavioural model state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_mdr, m_y, m_hi, m_lo, m_zh, m_zl;

  logic [31:0] exp_q [$];
  logic        chk_vld;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] model_bus();
    for (int i = 0; i < 16; i++) if (rout[i]) return m_r[i];
    if (HIout)    return m_hi;
    if (LOout)    return m_lo;
    if (Zhighout) return m_zh;
    if (Zlowout)  return m_zl;
    if (PCout)    return m_pc;
    if (MDRout)   return m_mdr;
    return 32'h0;
  endfunction

  function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic cin);
    logic [63:0] aa, t;
    longint      sa, sb, q, r;
    int          n;
    aa = {32'h0, a};
    n  = int'(b[4:0]);
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      5'b00011: return {32'h0, a + b + {31'h0, cin}};
      5'b00100: return {32'h0, a - b};
      5'b00101: return {32'h0, a & b};
      5'b00110: return {32'h0, a | b};
      5'b00111: begin t = (aa >> n) | (aa << (32 - n)); return {32'h0, t[31:0]}; end
      5'b01000: begin t = (aa << n) | (aa >> (32 - n)); return {32'h0, t[31:0]}; end
      5'b01001: return {32'h0, a >> n};
      5'b01010: return {32'h0, 32'(sa >>> n)};
      5'b01011: return {32'h0, a << n};
      5'b01111: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      5'b10000: return 64'(sa * sb);
      5'b10001: return {32'h0, 32'h0 - b};
      5'b10010: return {32'h0, ~b};
      default:  return 64'h0;
    endcase
  endfunction

  task automatic idle();
    Mdatain = '0; Read = 0; opcode = '0; Cin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; MDRout = 0; HIout = 0; LOout = 0;
    rout = '0; rin = '0;
    PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0; HIin = 0; LOin = 0;
    ZHighIn = 0; ZLowIn = 0; IncPC = 0;
    chk_vld = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_mdr = '0; m_y = '0; m_hi = '0; m_lo = '0; m_zh = '0; m_zl = '0;
  endtask

  // One clock cycle with the controls currently driven. Optionally queue the
  // expected bus value (model, or a literal for directed cases).
  task automatic step(input bit check, input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
    logic [31:0] nb;
    logic [63:0] alu;
    nb  = model_bus();
    alu = alu_model(m_y, nb, opcode, Cin);
    if (check) begin
      exp_q.push_back(use_lit ? lit : nb);
      chk_vld = 1'b1;
    end
    @(posedge clock);
    if (clear) begin
      for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = nb;
      if (PCin)       m_pc = nb;
      else if (IncPC) m_pc = m_pc + 32'd1;
      if (MDRin)   m_mdr = Read ? Mdatain : nb;
      if (Yin)     m_y  = nb;
      if (HIin)    m_hi = nb;
      if (LOin)    m_lo = nb;
      if (ZHighIn) m_zh = alu[63:32];
      if (ZLowIn)  m_zl = alu[31:0];
    end
    #1;
    idle();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] val);
    Mdatain = val; Read = 1; MDRin = 1; step(0);
    MDRout = 1; rin[idx] = 1; step(1);
  endtask

  task automatic show_r(input int idx, input logic [31:0] v);
    rout[idx] = 1; step(1, 1, v);
  endtask

  // Z low goes to a register and LO, Z high goes to HI.
  task automatic alu_op(input int ra, input int rb, input logic [4:0] op, input logic cin, input int dst);
    rout[ra] = 1; Yin = 1; step(0);
    rout[rb] = 1; opcode = op; Cin = cin; ZHighIn = 1; ZLowIn = 1; step(1);
    Zlowout = 1; rin[dst] = 1; LOin = 1; step(1);
    Zhighout = 1; HIin = 1; step(1);
  endtask

  task automatic show_hilo(input logic [31:0] h, input logic [31:0] l);
    HIout = 1; step(1, 1, h);
    LOout = 1; step(1, 1, l);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 40);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops and compares whenever the stimulus flags a bus check.
  always @(negedge clock) begin
    if (chk_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_check: nothing queued, bus=%h", BusMuxOut);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (BusMuxOut !== e) begin
          errors++;
          $display("FAIL bus_check #%0d at %0t: bus=%h expected=%h", checks, $time, BusMuxOut, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [4:0] ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                           5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};

  initial begin
    idle();
    model_reset();
    clear = 1'b0;
    @(posedge clock); #1;
    // Reset state while clear is held low
    rout[0] = 1; step(1, 1, 32'h0);
    PCout = 1; step(1, 1, 32'h0);
    clear = 1'b1;
    step(1, 1, 32'h0);                                  // no source -> 0

    // Load path and ROL
    load_reg(3, 32'h7F);
    show_r(3, 32'h7F);
    load_reg(7, 32'h1);
    alu_op(3, 7, 5'b01000, 1'b0, 4);
    show_r(4, 32'hFE);

    // MUL, DIV, DIV by zero, MUL corner
    load_reg(1, 32'hFFFF_FFFE); load_reg(2, 32'h3);
    alu_op(1, 2, 5'b10000, 1'b0, 5);
    show_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA);
    load_reg(1, 32'hFFFF_FFF9); load_reg(2, 32'h2);
    alu_op(1, 2, 5'b01111, 1'b0, 5);
    show_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    load_reg(2, 32'h0);
    alu_op(1, 2, 5'b01111, 1'b0, 5);
    show_hilo(32'hFFFF_FFF9, 32'hFFFF_FFFF);
    load_reg(1, 32'h8000_0000); load_reg(2, 32'h8000_0000);
    alu_op(1, 2, 5'b10000, 1'b0, 5);
    show_hilo(32'h4000_0000, 32'h0);

    // Zero rotate/shift amount, ADD with carry-in, SUB ignores carry-in
    load_reg(1, 32'h1234_5678); load_reg(2, 32'h20);    // B[4:0] = 0
    alu_op(1, 2, 5'b00111, 1'b0, 6); show_r(6, 32'h1234_5678);
    alu_op(1, 2, 5'b01010, 1'b0, 6); show_r(6, 32'h1234_5678);
    load_reg(1, 32'd5); load_reg(2, 32'd6);
    alu_op(1, 2, 5'b00011, 1'b1, 6); show_r(6, 32'd12);
    alu_op(1, 2, 5'b00100, 1'b1, 6); show_r(6, 32'hFFFF_FFFF);
    alu_op(1, 2, 5'b11111, 1'b0, 6); show_hilo(32'h0, 32'h0);  // undefined opcode

    // PC load, increment, wrap, load beats increment
    load_reg(8, 32'h7);
    rout[8] = 1; PCin = 1; step(0);
    IncPC = 1; step(0);
    PCout = 1; step(1, 1, 32'h8);
    load_reg(9, 32'hFFFF_FFFF);
    rout[9] = 1; PCin = 1; step(0);
    IncPC = 1; step(0);
    PCout = 1; step(1, 1, 32'h0);
    rout[3] = 1; PCin = 1; IncPC = 1; step(0);
    PCout = 1; step(1, 1, 32'h7F);

    // Priority
    rout[3] = 1; rout[7] = 1; HIout = 1; PCout = 1; step(1, 1, 32'h7F);
    LOout = 1; PCout = 1; MDRout = 1; step(1);
    Zlowout = 1; MDRout = 1; step(1);

    // Asynchronous reset between edges, loads ignored while low
    show_r(4, 32'hFE);
    clear = 1'b0; model_reset();
    rout[4] = 1; rin[5] = 1; IncPC = 1; step(1, 1, 32'h0);
    clear = 1'b1;
    show_r(5, 32'h0);
    PCout = 1; step(1, 1, 32'h0);
    HIout = 1; step(1, 1, 32'h0);
    rout[1] = 1; step(1, 1, 32'h0);
    step(1, 1, 32'h0);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom % 5)
        0: load_reg(int'($urandom % 16), rnd_val());
        1: alu_op(int'($urandom % 16), int'($urandom % 16),
                  ($urandom % 8 == 0) ? 5'($urandom) : ops[$urandom % 13],
                  1'($urandom), int'($urandom % 16));
        2: begin
          rout = 16'($urandom) & 16'($urandom) & 16'($urandom);
          {HIout, LOout, Zhighout, Zlowout, PCout, MDRout} = 6'($urandom);
          step(1);
        end
        3: begin
          rout[$urandom % 16] = 1; PCin = 1; step(0);
          IncPC = 1'($urandom); step(0);
          PCout = 1; step(1);
        end
        default: begin
          rout[$urandom % 16] = 1; MDRin = 1; Read = 0; step(0);
          MDRout = 1; step(1);
        end
      endcase
    end

    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
